sonar_scheduler: RTL and testbench
==================================

Name: sonar_scheduler

Overview:
- Sequences up to N MaxSonar sensors that share one PWM-to-distance converter (the block that outputs distance/new_dist).
- Fires one sensor at a time through its RX pin so sensors cannot crosstalk.
- Routes that sensor's PWM line to the converter and resets the converter between sensors.
- Captures each result into a per-sensor distance register, with timeout detection.

Parameters:
- N_SENSORS, 3, number of sensors; 1..8.
- RX_PULSE_CYC, 2000, RX high time in clk cycles (20 us at 100 MHz).
- TIMEOUT_CYC, 5_000_000, maximum cycles in WAIT before the sensor is declared dead (50 ms).
- GAP_CYC, 100_000, idle cycles between sensors (1 ms ring-down).

Ports:
- clk  in  1  system clock; one clock domain.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  level; 1 = run continuous round-robin scan.
- pwm_in  in  N_SENSORS  raw PWM lines from the sensors.
- rx_out  out  N_SENSORS  ranging-enable pins to the sensors; at most one high at a time.
- pwm_sel  out  1  pwm_in[cur_idx] routed to the converter's pwm input; 0 when not in TRIGGER or WAIT.
- conv_reset  out  1  one-cycle reset to the converter's reset input.
- distance_in  in  8  converter distance, in inches.
- new_dist_in  in  1  converter new_dist.
- dist_out  out  8*N_SENSORS  captured distance; sensor k occupies bits [8k+7:8k].
- valid_out  out  N_SENSORS  1 = dist_out slice holds a fresh, non-timeout result.
- update  out  1  one-cycle pulse when any slice is written.
- cur_idx  out  3  sensor currently being serviced.
- timeout  out  1  one-cycle pulse when WAIT expires.

Behaviour:
- Reset values:
  - State machine is in IDLE; cur_idx=0.
  - rx_out, pwm_sel, conv_reset, update and timeout are 0.
  - dist_out is all 0; valid_out is all 0.
  - Counters and the new_dist_prev register are 0.
- Reset asserted mid-operation overrides everything on the next edge, and rx_out drops in that same cycle.
- States:
  - IDLE: if enable=1, go to CONV_RST.
  - CONV_RST: conv_reset=1 for exactly 1 cycle, then go to TRIGGER.
  - TRIGGER: rx_out[cur_idx]=1 for RX_PULSE_CYC cycles; pwm_sel routed; then go to WAIT.
  - WAIT: rx_out=0; pwm_sel stays routed; the cycle counter increments.
    - On a rising edge of new_dist_in (new_dist_in=1 and new_dist_prev=0), go to STORE.
    - Else, when the counter reaches TIMEOUT_CYC-1, go to TOUT.
  - STORE: write distance_in into slice cur_idx; set valid_out[cur_idx]; update=1; go to GAP.
  - TOUT: write slice cur_idx to 8'hFF; clear valid_out[cur_idx]; timeout=1; update=1; go to GAP.
  - GAP: wait GAP_CYC cycles, then advance cur_idx.
    - cur_idx wraps from N_SENSORS-1 to 0.
    - If enable=1, go to CONV_RST; else go to IDLE.
- new_dist_prev is cleared in CONV_RST. A new_dist level left over from the previous sensor therefore never triggers a capture.
- The converter updates distance on the same edge its new_dist rises, so distance_in is stable in the cycle the rising edge is detected. Capture latency is one cycle after detection.
- When the edge and the timeout fall on the same cycle, the edge wins (STORE).
- enable deasserted mid-cycle: the current sensor completes through GAP, then the block goes to IDLE. dist_out and valid_out are retained.
- With N_SENSORS=1, the block re-fires the same sensor every round.
- Counters are 32 bit unsigned, cleared on every state entry.

Optional Feature:
- SONAR_SCHED_MINDIST_EN defined:
  - Adds outputs min_dist[7:0] and min_idx[2:0], registered.
  - They are recomputed in the cycle after each update, over sensors with valid_out=1.
  - Ties resolve to the lower index.
  - If no sensor is valid: min_dist=8'hFF, min_idx=0.
  - Both reset to those same values.
- SONAR_SCHED_MINDIST_EN undefined: the ports and logic are absent.

Decomposition:
- Package sonar_pkg holds:
  - the state enum (IDLE, CONV_RST, TRIGGER, WAIT, STORE, TOUT, GAP), 3 bits;
  - DIST_TIMEOUT = 8'hFF;
  - the width constants.
- One sub-module, sonar_min_finder: combinational min over N slices with a valid mask. Instantiated only under SONAR_SCHED_MINDIST_EN.

Test Plan:
Bench parameters: N_SENSORS=3, RX_PULSE_CYC=4, TIMEOUT_CYC=200, GAP_CYC=8. The converter is modelled directly.
- Reset, then enable=1 -> conv_reset pulses, then rx_out=3'b001 for exactly 4 cycles, pwm_sel follows pwm_in[0].
- Sensor 0 model: new_dist_in rises with distance_in=8'd42 at WAIT cycle 50 -> dist_out[7:0]=42, valid_out[0]=1, one update pulse, cur_idx becomes 1 after 8 gap cycles.
- Sensor 1 silent -> after 200 WAIT cycles: timeout pulse, slice 1=8'hFF, valid_out[1]=0; scan proceeds to sensor 2, then wraps to 0.
- new_dist_in held high from the previous sensor into the next -> no capture until it falls and rises again.
- Assert reset during TRIGGER of sensor 2 -> next cycle rx_out=0, dist_out=0, valid_out=0, state IDLE.
- With SONAR_SCHED_MINDIST_EN, sensors return 30, 12, 12 -> min_dist=12, min_idx=1.

Source files
------------

// File: rtl/sonar_pkg.sv
// ----------------------------------------------------------------------------
// sonar_pkg
// Shared definitions for the MaxSonar round-robin scheduler:
//   - sonarState_t : scheduler state encoding (3 bits)
//   - DIST_W       : width of one distance slice (inches, 8 bits)
//   - IDX_W        : width of a sensor index (up to 8 sensors)
//   - CNT_W        : width of the state cycle counter
//   - DIST_TIMEOUT : value written into a slice when its sensor never answers
// ----------------------------------------------------------------------------
package sonar_pkg;

    localparam int DIST_W = 8;
    localparam int IDX_W  = 3;
    localparam int CNT_W  = 32;

    localparam logic [DIST_W-1:0] DIST_TIMEOUT = 8'hFF;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CONV_RST = 3'd1,
        TRIGGER  = 3'd2,
        WAIT     = 3'd3,
        STORE    = 3'd4,
        TOUT     = 3'd5,
        GAP      = 3'd6
    } sonarState_t;

endpackage

// File: rtl/sonar_min_finder.sv
// ----------------------------------------------------------------------------
// sonar_min_finder
// Purely combinational search for the smallest valid distance among N slices.
// Ports:
//   i_dist    [DIST_W*N-1:0] packed distance slices, slice k at [8k+7:8k]
//   i_valid   [N-1:0]        slice k takes part in the search when set
//   o_minDist [DIST_W-1:0]   smallest valid distance, DIST_TIMEOUT if none
//   o_minIdx  [IDX_W-1:0]    index of that slice, 0 if none valid
// ----------------------------------------------------------------------------
module sonar_min_finder
    import sonar_pkg::*;
#(
    parameter int N = 3
) (
    input  logic [DIST_W*N-1:0] i_dist,
    input  logic [N-1:0]        i_valid,
    output logic [DIST_W-1:0]   o_minDist,
    output logic [IDX_W-1:0]    o_minIdx
);

    logic [DIST_W-1:0] w_best;
    logic [IDX_W-1:0]  w_bestIdx;
    logic              w_found;

    // Linear scan from index 0 upward. The first valid slice is always taken,
    // after that only a strictly smaller value replaces the candidate, so on
    // equal distances the lower index is kept.
    always_comb begin
        w_best    = DIST_TIMEOUT;
        w_bestIdx = '0;
        w_found   = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (i_valid[k] && (!w_found || (i_dist[DIST_W*k +: DIST_W] < w_best))) begin
                w_best    = i_dist[DIST_W*k +: DIST_W];
                w_bestIdx = IDX_W'(k);
                w_found   = 1'b1;
            end
        end
    end

    assign o_minDist = w_best;
    assign o_minIdx  = w_bestIdx;

endmodule

// File: rtl/sonar_scheduler.sv
// ----------------------------------------------------------------------------
// sonar_scheduler
// Fires up to N_SENSORS MaxSonar sensors one at a time, routes the active
// sensor's PWM line to a shared PWM-to-distance converter, resets that
// converter between sensors and captures each result (or a timeout marker)
// into a per-sensor distance register.
//
// Ports:
//   clk          system clock
//   reset        synchronous active-high reset
//   enable       level, 1 = keep scanning round-robin
//   pwm_in       raw PWM lines from the sensors
//   rx_out       ranging-enable pins, at most one high
//   pwm_sel      selected PWM line towards the converter
//   conv_reset   one-cycle reset pulse to the converter
//   distance_in  converter distance (inches)
//   new_dist_in  converter new-result flag
//   dist_out     captured distances, sensor k at [8k+7:8k]
//   valid_out    per-sensor fresh non-timeout result flag
//   update       one-cycle pulse whenever a slice is written
//   cur_idx      sensor currently being serviced
//   timeout      one-cycle pulse when a sensor fails to answer
//   min_dist     (SONAR_SCHED_MINDIST_EN only) smallest valid distance
//   min_idx      (SONAR_SCHED_MINDIST_EN only) index of that sensor
//
// Optional feature macro: SONAR_SCHED_MINDIST_EN
// ----------------------------------------------------------------------------
module sonar_scheduler
    import sonar_pkg::*;
#(
    parameter int N_SENSORS    = 3,
    parameter int RX_PULSE_CYC = 2000,
    parameter int TIMEOUT_CYC  = 5_000_000,
    parameter int GAP_CYC      = 100_000
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        enable,
    input  logic [N_SENSORS-1:0]        pwm_in,
    output logic [N_SENSORS-1:0]        rx_out,
    output logic                        pwm_sel,
    output logic                        conv_reset,
    input  logic [DIST_W-1:0]           distance_in,
    input  logic                        new_dist_in,
    output logic [DIST_W*N_SENSORS-1:0] dist_out,
    output logic [N_SENSORS-1:0]        valid_out,
    output logic                        update,
    output logic [IDX_W-1:0]            cur_idx,
    output logic                        timeout
`ifdef SONAR_SCHED_MINDIST_EN
    ,
    output logic [DIST_W-1:0]           min_dist,
    output logic [IDX_W-1:0]            min_idx
`endif
);

    localparam logic [CNT_W-1:0] RX_LAST   = CNT_W'(RX_PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] TOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYC - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_SENSORS - 1);

    sonarState_t                 r_state;
    logic [CNT_W-1:0]            r_cnt;
    logic [IDX_W-1:0]            r_curIdx;
    logic [N_SENSORS-1:0]        r_rx;
    logic                        r_convReset;
    logic                        r_update;
    logic                        r_timeout;
    logic [DIST_W*N_SENSORS-1:0] r_dist;
    logic [N_SENSORS-1:0]        r_valid;
    logic                        r_ndPrev;

    logic [N_SENSORS-1:0]        w_rxOneHot;
    logic                        w_pwmSel;
    logic                        w_route;
    logic                        w_ndRise;
    logic [IDX_W-1:0]            w_nextIdx;

    // Decode the current sensor index into a one-hot RX pattern and pick out
    // that sensor's PWM line. Done with a compare loop so the index width never
    // has to match the (parameter dependent) vector width.
    always_comb begin
        w_rxOneHot = '0;
        w_pwmSel   = 1'b0;
        for (int k = 0; k < N_SENSORS; k++) begin
            if (r_curIdx == IDX_W'(k)) begin
                w_rxOneHot[k] = 1'b1;
                w_pwmSel      = pwm_in[k];
            end
        end
    end

    // The PWM route is only open while the sensor is ranging or being waited
    // on; everywhere else the converter sees a quiet line.
    assign w_route   = (r_state == TRIGGER) || (r_state == WAIT);
    assign pwm_sel   = w_route & w_pwmSel;

    // A capture is only triggered by a fresh rising edge of new_dist, never by
    // a level that was already high.
    assign w_ndRise  = new_dist_in & ~r_ndPrev;

    assign w_nextIdx = (r_curIdx == IDX_LAST) ? '0 : r_curIdx + IDX_W'(1);

    // RX is gated by reset directly so a sensor stops ranging in the very
    // cycle reset is raised, not one edge later.
    assign rx_out     = reset ? '0 : r_rx;
    assign conv_reset = r_convReset;
    assign update     = r_update;
    assign timeout    = r_timeout;
    assign dist_out   = r_dist;
    assign valid_out  = r_valid;
    assign cur_idx    = r_curIdx;

    // Main scheduler. Outputs are registered alongside the state so each
    // output lines up with the state it belongs to: conv_reset is set on the
    // way into CONV_RST, RX on the way into TRIGGER, and the slice write plus
    // update/timeout pulses on the way into STORE/TOUT. The counter is cleared
    // on every state change. new_dist history is tracked in every state except
    // CONV_RST, where it is cleared, so a level held over from the previous
    // sensor is already "old" by the time WAIT starts looking for an edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_curIdx    <= '0;
            r_rx        <= '0;
            r_convReset <= 1'b0;
            r_update    <= 1'b0;
            r_timeout   <= 1'b0;
            r_dist      <= '0;
            r_valid     <= '0;
            r_ndPrev    <= 1'b0;
        end else begin
            r_convReset <= 1'b0;
            r_update    <= 1'b0;
            r_timeout   <= 1'b0;
            r_ndPrev    <= new_dist_in;

            case (r_state)
                IDLE: begin
                    if (enable) begin
                        r_state     <= CONV_RST;
                        r_convReset <= 1'b1;
                        r_cnt       <= '0;
                    end
                end

                CONV_RST: begin
                    r_state  <= TRIGGER;
                    r_rx     <= w_rxOneHot;
                    r_ndPrev <= 1'b0;
                    r_cnt    <= '0;
                end

                TRIGGER: begin
                    if (r_cnt == RX_LAST) begin
                        r_state <= WAIT;
                        r_rx    <= '0;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end

                WAIT: begin
                    if (w_ndRise) begin
                        r_state  <= STORE;
                        r_update <= 1'b1;
                        r_cnt    <= '0;
                        for (int k = 0; k < N_SENSORS; k++) begin
                            if (r_curIdx == IDX_W'(k)) begin
                                r_dist[DIST_W*k +: DIST_W] <= distance_in;
                                r_valid[k]                 <= 1'b1;
                            end
                        end
                    end else if (r_cnt == TOUT_LAST) begin
                        r_state   <= TOUT;
                        r_update  <= 1'b1;
                        r_timeout <= 1'b1;
                        r_cnt     <= '0;
                        for (int k = 0; k < N_SENSORS; k++) begin
                            if (r_curIdx == IDX_W'(k)) begin
                                r_dist[DIST_W*k +: DIST_W] <= DIST_TIMEOUT;
                                r_valid[k]                 <= 1'b0;
                            end
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end

                STORE, TOUT: begin
                    r_state <= GAP;
                    r_cnt   <= '0;
                end

                GAP: begin
                    if (r_cnt == GAP_LAST) begin
                        r_curIdx <= w_nextIdx;
                        r_cnt    <= '0;
                        if (enable) begin
                            r_state     <= CONV_RST;
                            r_convReset <= 1'b1;
                        end else begin
                            r_state <= IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end

                default: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                    r_rx    <= '0;
                end
            endcase
        end
    end

`ifdef SONAR_SCHED_MINDIST_EN
    logic [DIST_W-1:0] w_minDist;
    logic [IDX_W-1:0]  w_minIdx;
    logic [DIST_W-1:0] r_minDist;
    logic [IDX_W-1:0]  r_minIdx;

    sonar_min_finder #(
        .N (N_SENSORS)
    ) u_minFinder (
        .i_dist    (r_dist),
        .i_valid   (r_valid),
        .o_minDist (w_minDist),
        .o_minIdx  (w_minIdx)
    );

    // The slices change on the same edge that raises update, so while update
    // is high the finder already sees the new contents; latching then gives
    // the refreshed minimum one cycle after the update pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_minDist <= DIST_TIMEOUT;
            r_minIdx  <= '0;
        end else if (r_update) begin
            r_minDist <= w_minDist;
            r_minIdx  <= w_minIdx;
        end
    end

    assign min_dist = r_minDist;
    assign min_idx  = r_minIdx;
`endif

endmodule

// File: tb/tb_sonar_scheduler.sv
// ----------------------------------------------------------------------------
// tb_sonar_scheduler
// Self-checking bench for sonar_scheduler with a small configuration
// (3 sensors, 4-cycle RX pulse, 200-cycle timeout, 8-cycle gap). The shared
// converter is modelled directly: per sensor the bench decides whether it
// answers, at which WAIT cycle, with what distance, and whether new_dist is
// left stuck high from the previous sensor. Expected results are kept in a
// per-sensor array and the scan order is tracked as a plain modulo counter.
// Optional feature macro: SONAR_SCHED_MINDIST_EN
// ----------------------------------------------------------------------------
module tb_sonar_scheduler;

    localparam int N    = 3;
    localparam int RX   = 4;
    localparam int TMO  = 200;
    localparam int GAPC = 8;

    logic           clk = 1'b0;
    logic           reset;
    logic           enable;
    logic [N-1:0]   pwm_in;
    logic [N-1:0]   rx_out;
    logic           pwm_sel;
    logic           conv_reset;
    logic [7:0]     distance_in;
    logic           new_dist_in;
    logic [8*N-1:0] dist_out;
    logic [N-1:0]   valid_out;
    logic           update;
    logic [2:0]     cur_idx;
    logic           timeout;
`ifdef SONAR_SCHED_MINDIST_EN
    logic [7:0]     min_dist;
    logic [2:0]     min_idx;
`endif

    int errCount   = 0;
    int checkCount = 0;

    logic [7:0] expDist  [N];
    logic       expValid [N];
    int         expIdx;
    logic [7:0] minVals  [N];

    sonar_scheduler #(
        .N_SENSORS    (N),
        .RX_PULSE_CYC (RX),
        .TIMEOUT_CYC  (TMO),
        .GAP_CYC      (GAPC)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .pwm_in      (pwm_in),
        .rx_out      (rx_out),
        .pwm_sel     (pwm_sel),
        .conv_reset  (conv_reset),
        .distance_in (distance_in),
        .new_dist_in (new_dist_in),
        .dist_out    (dist_out),
        .valid_out   (valid_out),
        .update      (update),
        .cur_idx     (cur_idx),
        .timeout     (timeout)
`ifdef SONAR_SCHED_MINDIST_EN
        ,
        .min_dist    (min_dist),
        .min_idx     (min_idx)
`endif
    );

    // 10-unit clock period.
    always #5 clk = ~clk;

    // Safety net so the run always ends even if the design locks up.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errCount + 1, checkCount + 1);
        $fatal(1, "[TB] watchdog expired");
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checkCount++;
        if (obs !== exp) begin
            errCount++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Packs the expected per-sensor distances the same way dist_out is laid out.
    function automatic logic [8*N-1:0] expDistVec();
        logic [8*N-1:0] v;
        for (int k = 0; k < N; k++) v[8*k +: 8] = expDist[k];
        return v;
    endfunction

    function automatic logic [N-1:0] expValidVec();
        logic [N-1:0] v;
        for (int k = 0; k < N; k++) v[k] = expValid[k];
        return v;
    endfunction

    // Clears the expected picture back to the post-reset state.
    task automatic modelReset();
        for (int k = 0; k < N; k++) begin
            expDist[k]  = 8'h00;
            expValid[k] = 1'b0;
        end
        expIdx = 0;
    endtask

`ifdef SONAR_SCHED_MINDIST_EN
    // Minimum over the valid sensors; on equal distance the earlier sensor
    // stays; nothing valid gives FF / 0.
    task automatic checkMin();
        logic [7:0] best;
        int         bestIdx;
        bit         found;
        best    = 8'hFF;
        bestIdx = 0;
        found   = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (expValid[k] && (!found || expDist[k] < best)) begin
                best    = expDist[k];
                bestIdx = k;
                found   = 1'b1;
            end
        end
        checkOutput("minDist", min_dist, best);
        checkOutput("minIdx", min_idx, bestIdx);
    endtask
`endif

    // Services one sensor end to end: waits for the converter reset, checks the
    // RX pulse and PWM routing, plays the converter (answer at WAIT cycle d with
    // distance dv, or stay silent, optionally with new_dist stuck high from the
    // previous sensor), checks the capture or timeout, then the gap length and
    // the hand-over to the next sensor.
    task automatic applyStimulus(input bit respond, input bit stale, input int d, input logic [7:0] dv);
        int         n;
        int         idx;
        int         hitW;
        bit         hit;
        logic [N-1:0] oneHot;

        idx = expIdx;
        n   = 0;
        while (conv_reset !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        checkOutput("convRst", conv_reset, 1'b1);
        checkOutput("curIdxStart", cur_idx, idx);

        new_dist_in = stale;
        distance_in = 8'($urandom);
        oneHot      = '0;
        oneHot[idx] = 1'b1;

        for (int c = 0; c < RX; c++) begin
            @(negedge clk);
            pwm_in = N'($urandom);
            #1;
            checkOutput("rxOn", rx_out, oneHot);
            checkOutput("pwmTrig", pwm_sel, pwm_in[idx]);
            if (c == 0) checkOutput("convPulse", conv_reset, 1'b0);
        end

        hit  = 1'b0;
        hitW = -1;
        for (int w = 0; w < TMO + 10 && !hit; w++) begin
            @(negedge clk);
            if (update === 1'b1) begin
                hit  = 1'b1;
                hitW = w;
            end else begin
                if (w == 0) checkOutput("rxOff", rx_out, '0);
                if (w < 3) begin
                    pwm_in = N'($urandom);
                    #1;
                    checkOutput("pwmWait", pwm_sel, pwm_in[idx]);
                end
                if (stale && respond && w == d - 1) new_dist_in = 1'b0;
                if (respond && w == d) begin
                    new_dist_in = 1'b1;
                    distance_in = dv;
                end
            end
        end

        checkOutput("updSeen", hit, 1'b1);
        checkOutput("updCycle", hitW, respond ? d + 1 : TMO);
        if (respond) begin
            expDist[idx]  = dv;
            expValid[idx] = 1'b1;
        end else begin
            expDist[idx]  = 8'hFF;
            expValid[idx] = 1'b0;
        end
        checkOutput("toutPulse", timeout, !respond);
        checkOutput("distOut", dist_out, expDistVec());
        checkOutput("validOut", valid_out, expValidVec());

        @(negedge clk);
        checkOutput("updOnce", update, 1'b0);
        checkOutput("toutOnce", timeout, 1'b0);
        checkOutput("pwmGap", pwm_sel, 1'b0);
`ifdef SONAR_SCHED_MINDIST_EN
        checkMin();
`endif

        n = 1;
        while (cur_idx === 3'(idx) && n < GAPC + 10) begin
            @(negedge clk);
            n++;
        end
        checkOutput("gapLen", n, GAPC + 1);
        expIdx = (idx + 1) % N;
        checkOutput("curIdxNext", cur_idx, expIdx);
        checkOutput("convNext", conv_reset, enable);
    endtask

    // One sensor with randomly chosen converter behaviour.
    task automatic randomService();
        bit         respond;
        bit         stale;
        int         d;
        respond = ($urandom_range(0, 3) != 0);
        stale   = ($urandom_range(0, 2) == 0);
        d       = $urandom_range(2, TMO - 1);
        applyStimulus(respond, stale, d, 8'($urandom));
    endtask

    initial begin
        reset       = 1'b1;
        enable      = 1'b0;
        pwm_in      = '1;
        new_dist_in = 1'b0;
        distance_in = 8'h00;
        minVals[0]  = 8'd30;
        minVals[1]  = 8'd12;
        minVals[2]  = 8'd12;
        modelReset();

        repeat (3) @(negedge clk);
        $display("[TB] checking reset state");
        checkOutput("rstRx", rx_out, '0);
        checkOutput("rstPwm", pwm_sel, 1'b0);
        checkOutput("rstConv", conv_reset, 1'b0);
        checkOutput("rstUpd", update, 1'b0);
        checkOutput("rstTout", timeout, 1'b0);
        checkOutput("rstDist", dist_out, '0);
        checkOutput("rstValid", valid_out, '0);
        checkOutput("rstIdx", cur_idx, 0);
`ifdef SONAR_SCHED_MINDIST_EN
        checkMin();
`endif
        reset = 1'b0;

        // With enable low the block must sit in IDLE.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("idleConv", conv_reset, 1'b0);
        end

        $display("[TB] directed scan");
        enable = 1'b1;
        applyStimulus(1'b1, 1'b0, 50, 8'd42);
        applyStimulus(1'b0, 1'b0, 0, 8'd0);
        applyStimulus(1'b1, 1'b0, $urandom_range(0, TMO - 1), 8'($urandom));
        applyStimulus(1'b1, 1'b1, $urandom_range(2, TMO - 1), 8'($urandom));
        applyStimulus(1'b1, 1'b0, TMO - 1, 8'($urandom));
        applyStimulus(1'b0, 1'b1, 0, 8'd0);

        $display("[TB] random scan");
        for (int i = 0; i < 6; i++) randomService();

        $display("[TB] enable dropped mid-scan");
        enable = 1'b0;
        randomService();
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            checkOutput("offConv", conv_reset, 1'b0);
            checkOutput("offRx", rx_out, '0);
            checkOutput("offDist", dist_out, expDistVec());
            checkOutput("offValid", valid_out, expValidVec());
            checkOutput("offIdx", cur_idx, expIdx);
        end
        enable = 1'b1;

        $display("[TB] minimum distance round");
        for (int i = 0; i < N; i++) applyStimulus(1'b1, 1'b0, $urandom_range(5, 60), minVals[expIdx]);
`ifdef SONAR_SCHED_MINDIST_EN
        checkOutput("minRoundDist", min_dist, 8'd12);
        checkOutput("minRoundIdx", min_idx, 1);
`endif

        $display("[TB] reset during trigger of sensor 2");
        for (int i = 0; i < N && expIdx != 2; i++) applyStimulus(1'b1, 1'b0, $urandom_range(0, 40), 8'($urandom));
        begin
            int n;
            n = 0;
            while (conv_reset !== 1'b1 && n < 40) begin
                @(negedge clk);
                n++;
            end
        end
        checkOutput("preRstIdx", cur_idx, 2);
        @(negedge clk);
        @(negedge clk);
        checkOutput("preRstRx", rx_out, 3'b100);
        reset  = 1'b1;
        enable = 1'b0;
        pwm_in = '1;
        #1;
        checkOutput("rstRxNow", rx_out, '0);
        @(negedge clk);
        modelReset();
        checkOutput("midRstRx", rx_out, '0);
        checkOutput("midRstDist", dist_out, '0);
        checkOutput("midRstValid", valid_out, '0);
        checkOutput("midRstIdx", cur_idx, 0);
        checkOutput("midRstUpd", update, 1'b0);
        checkOutput("midRstPwm", pwm_sel, 1'b0);
`ifdef SONAR_SCHED_MINDIST_EN
        checkMin();
`endif
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("postRstIdle", conv_reset, 1'b0);
        end
        enable = 1'b1;
        applyStimulus(1'b1, 1'b0, $urandom_range(0, 40), 8'($urandom));

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
